// File: rtl/hex_print_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : hex_print_ctrl
//  Purpose  : Turns a WIDTH-bit binary value into a stream of lowercase ASCII
//             hex characters, MSB nibble first, one character per accepted
//             output beat. An optional separator character follows the last
//             digit. Only one value is in flight at a time.
//  Option   : HEX_PRINT_CTRL_PREFIX_EN - when defined, "0x" is emitted before
//             the first digit.
//  Ports    : clk        - clock, all state on rising edge
//             rst        - asynchronous active-high reset
//             req_valid  - a value is offered
//             req_ready  - idle and able to accept a value
//             req_value  - value to print, sampled on accept
//             out_valid  - out_char is valid
//             out_ready  - downstream accepts out_char
//             out_char   - ASCII character
//             out_last   - final character of the current value
//             busy       - high from accept until the final output handshake
//  Revision : 1.0 - initial release
// ============================================================================
module hex_print_ctrl #(
  parameter int         WIDTH    = 32,
  parameter logic [7:0] SEP_CHAR = 8'h00
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_value,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_char,
  output logic             out_last,
  output logic             busy
);

  localparam int NIBBLES = WIDTH / 4;
  localparam int CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(NIBBLES - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
`ifdef HEX_PRINT_CTRL_PREFIX_EN
  localparam logic [1:0] S_PREFIX = 2'd1;
`endif
  localparam logic [1:0] S_DIGIT  = 2'd2;
  localparam logic [1:0] S_SEP    = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] value_q, value_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
`ifdef HEX_PRINT_CTRL_PREFIX_EN
  // 0 while the '0' beat is shown, 1 while the 'x' beat is shown
  logic             pfx_q,   pfx_d;
`endif

  logic       req_accept;
  logic [3:0] nibble;
  logic [7:0] digit_char;

  assign req_accept = req_valid & req_ready;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      value_q <= '0;
      cnt_q   <= '0;
`ifdef HEX_PRINT_CTRL_PREFIX_EN
      pfx_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      value_q <= value_d;
      cnt_q   <= cnt_d;
`ifdef HEX_PRINT_CTRL_PREFIX_EN
      pfx_q   <= pfx_d;
`endif
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic. Every emitting state advances only on out_ready, which
  // keeps the shown character frozen during backpressure.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    value_d = value_q;
    cnt_d   = cnt_q;
`ifdef HEX_PRINT_CTRL_PREFIX_EN
    pfx_d   = pfx_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req_accept) begin
          value_d = req_value;
          cnt_d   = CNT_TOP;
`ifdef HEX_PRINT_CTRL_PREFIX_EN
          state_d = S_PREFIX;
          pfx_d   = 1'b0;
`else
          state_d = S_DIGIT;
`endif
        end
      end
`ifdef HEX_PRINT_CTRL_PREFIX_EN
      S_PREFIX: begin
        if (out_ready) begin
          if (pfx_q) begin
            state_d = S_DIGIT;
          end
          pfx_d = ~pfx_q;
        end
      end
`endif
      S_DIGIT: begin
        if (out_ready) begin
          if (cnt_q == '0) begin
            state_d = (SEP_CHAR != 8'h00) ? S_SEP : S_IDLE;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      S_SEP: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Output logic
  // --------------------------------------------------------------------------
  // Select the nibble addressed by the down-counter
  always_comb begin
    nibble = 4'h0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (cnt_q == i[CNT_W-1:0]) begin
        nibble = value_q[4*i +: 4];
      end
    end
  end

  // 'a' - 10 = 8'h57
  assign digit_char = (nibble < 4'd10) ? (8'h30 + {4'h0, nibble})
                                       : (8'h57 + {4'h0, nibble});

  always_comb begin
    // req_ready is gated by rst so nothing is offered as acceptable in reset
    req_ready = (state_q == S_IDLE) & ~rst;
    busy      = (state_q != S_IDLE);
    out_valid = 1'b0;
    out_char  = 8'h00;
    out_last  = 1'b0;
    case (state_q)
`ifdef HEX_PRINT_CTRL_PREFIX_EN
      S_PREFIX: begin
        out_valid = 1'b1;
        out_char  = pfx_q ? 8'h78 : 8'h30;
      end
`endif
      S_DIGIT: begin
        out_valid = 1'b1;
        out_char  = digit_char;
        out_last  = (cnt_q == '0) && (SEP_CHAR == 8'h00);
      end
      S_SEP: begin
        out_valid = 1'b1;
        out_char  = SEP_CHAR;
        out_last  = 1'b1;
      end
      default: begin
        out_valid = 1'b0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_hex_print_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hex_print_ctrl
//  Purpose  : Self-checking bench for hex_print_ctrl. Two instances with
//             WIDTH=16: index 0 without separator, index 1 with a space
//             separator. Expected character streams come from a string-based
//             reference model; HEX_PRINT_CTRL_PREFIX_EN adds "0x" to it.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_hex_print_ctrl;

  localparam int W = 16;
  localparam int N = W / 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]   req_valid, req_ready, out_valid, out_ready, out_last, busy;
  logic [W-1:0] req_value [2];
  logic [7:0]   out_char  [2];

  int total = 0;
  int bad   = 0;

  hex_print_ctrl #(.WIDTH(W), .SEP_CHAR(8'h00)) u_dut0 (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid[0]),
    .req_ready (req_ready[0]),
    .req_value (req_value[0]),
    .out_valid (out_valid[0]),
    .out_ready (out_ready[0]),
    .out_char  (out_char[0]),
    .out_last  (out_last[0]),
    .busy      (busy[0])
  );

  hex_print_ctrl #(.WIDTH(W), .SEP_CHAR(8'h20)) u_dut1 (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid[1]),
    .req_ready (req_ready[1]),
    .req_value (req_value[1]),
    .out_valid (out_valid[1]),
    .out_ready (out_ready[1]),
    .out_char  (out_char[1]),
    .out_last  (out_last[1]),
    .busy      (busy[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Called and returns on a negedge. mode: 0 = out_ready always 1,
  // 1 = random out_ready, 2 = fixed pattern 1,0,0,1,0,1,1 then 1.
  // hold_next keeps req_valid asserted with next_v after the accept.
  task automatic run_value(input int sel, input logic [W-1:0] v, input int mode,
                           input bit hold_next, input logic [W-1:0] next_v);
    byte unsigned exp_q[$];
    string hexs = "0123456789abcdef";
    int    pat [7] = '{1, 0, 0, 1, 0, 1, 1};
    int    idx, cyc;
    bit    rdy;
`ifdef HEX_PRINT_CTRL_PREFIX_EN
    exp_q.push_back(8'h30);
    exp_q.push_back(8'h78);
`endif
    for (int i = N - 1; i >= 0; i--) begin
      exp_q.push_back(hexs[int'((v >> (4 * i)) & 16'hf)]);
    end
    if (sel == 1) exp_q.push_back(8'h20);

    req_value[sel] = v;
    req_valid[sel] = 1'b1;
    out_ready[sel] = 1'b0;
    check("req_ready_before_accept", req_ready[sel], 1);
    @(negedge clk);
    if (hold_next) req_value[sel] = next_v;
    else           req_valid[sel] = 1'b0;

    idx = 0;
    cyc = 0;
    while (idx < exp_q.size()) begin
      check("out_valid", out_valid[sel], 1);
      check("out_char", out_char[sel], exp_q[idx]);
      check("out_last", out_last[sel], (idx == exp_q.size() - 1));
      check("busy_active", busy[sel], 1);
      check("req_ready_active", req_ready[sel], 0);
      if (mode == 0)      rdy = 1'b1;
      else if (mode == 2) rdy = (cyc < 7) ? pat[cyc][0] : 1'b1;
      else                rdy = ($urandom_range(0, 3) != 0);
      out_ready[sel] = rdy;
      if (rdy) idx++;
      cyc++;
      @(negedge clk);
      if (cyc > 200) begin
        check("timeout", 0, 1);
        break;
      end
    end
    out_ready[sel] = 1'b0;
    check("idle_out_valid", out_valid[sel], 0);
    check("idle_out_last", out_last[sel], 0);
    check("idle_busy", busy[sel], 0);
    check("idle_req_ready", req_ready[sel], 1);
    if (mode == 0) check("beats_per_value", cyc, exp_q.size());
  endtask

  initial begin
    rst          = 1'b1;
    req_valid    = '0;
    out_ready    = '0;
    req_value[0] = '0;
    req_value[1] = '0;
    #12;
    for (int s = 0; s < 2; s++) begin
      check("rst_req_ready", req_ready[s], 0);
      check("rst_out_valid", out_valid[s], 0);
      check("rst_out_char", out_char[s], 0);
      check("rst_out_last", out_last[s], 0);
      check("rst_busy", busy[s], 0);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_ready0", req_ready[0], 1);
    check("post_rst_ready1", req_ready[1], 1);
    @(negedge clk);

    // Directed cases
    run_value(0, 16'h1a2f, 0, 1'b0, '0);
    run_value(0, 16'hbeef, 2, 1'b0, '0);
    run_value(1, 16'h0000, 0, 1'b0, '0);
    run_value(1, 16'hffff, 2, 1'b0, '0);
    run_value(0, 16'h0000, 0, 1'b0, '0);
    // Second request held valid while the first is in flight
    run_value(0, 16'h1234, 0, 1'b1, 16'hffff);
    run_value(0, 16'hffff, 0, 1'b0, '0);

    // Reset in the middle of a print
    req_value[0] = 16'h1234;
    req_valid[0] = 1'b1;
    check("mid_rst_accept_ready", req_ready[0], 1);
    @(negedge clk);
    req_valid[0] = 1'b0;
    out_ready[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
`ifndef HEX_PRINT_CTRL_PREFIX_EN
    check("mid_rst_third_char", out_char[0], 8'h33);
`endif
    #2 rst = 1'b1;
    #1;
    check("mid_rst_out_valid", out_valid[0], 0);
    check("mid_rst_busy", busy[0], 0);
    check("mid_rst_out_last", out_last[0], 0);
    check("mid_rst_req_ready", req_ready[0], 0);
    @(negedge clk);
    rst          = 1'b0;
    out_ready[0] = 1'b0;
    @(posedge clk);
    #1;
    check("mid_rst_ready_back", req_ready[0], 1);
    check("mid_rst_still_idle", out_valid[0], 0);
    @(negedge clk);
    run_value(0, 16'h5678, 0, 1'b0, '0);

    // Randomized values, DUT choice and backpressure
    for (int k = 0; k < 24; k++) begin
      run_value(int'($urandom_range(0, 1)), W'($urandom), int'($urandom_range(0, 1)),
                1'b0, '0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
